// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and helpers for the TDM 8:1 transmit link
//
// Purpose : channel count, select width, FSM state encoding and the
//           channel-number to select-code mapping used by the serializer.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int GAP_W  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Channel k (1..NUM_CH) is routed by the demux when the select equals k-1.
  function automatic logic [SEL_W-1:0] ch_sel(input int ch);
    return SEL_W'(ch - 1);
  endfunction

endpackage

// File: rtl/tdm_sel_counter.sv
// rtl/tdm_sel_counter.sv - small up-counter with clear, enable and terminal flag
//
// Purpose : W-bit counter; clr has priority over en; last is high while the
//           count equals max_val.
// Ports   : clk, rst (async, active high)
//           clr      - synchronous clear to zero
//           en       - increment by one
//           max_val  - terminal count compared against cnt
//           cnt      - current count
//           last     - cnt == max_val
module tdm_sel_counter
  import tdm_pkg::*;
#(
  parameter int W = SEL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = (cnt == max_val);

endmodule

// File: rtl/tdm_mux8_tx.sv
// rtl/tdm_mux8_tx.sv - 8:1 TDM serializer feeding a 3-bit-select 1:8 demux
//
// Purpose : captures an 8-channel frame on load_valid/load_ready, then drives
//           one channel per cycle on A with its index on S3..S1.
// Ports   : clk, rst (async, active high)
//           load_valid/load_ready - frame load handshake (ready only in IDLE)
//           din        - 8*DW frame, channel k at din[k*DW-1:(k-1)*DW]
//           hold       - receiver stall, only honoured while shifting
//           A          - serialized channel data
//           S3,S2,S1   - channel select MSB..LSB
//           a_valid    - A/S carry a fresh channel this cycle
//           busy       - not IDLE
//           frame_done - one-cycle pulse after channel 8 has gone out
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int DW        = 1,
  parameter int FRAME_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [8*DW-1:0]  din,
  input  logic             hold,
  output logic [DW-1:0]    A,
  output logic             S3,
  output logic             S2,
  output logic             S1,
  output logic             a_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [GAP_W-1:0] GAP_MAX =
    (FRAME_GAP == 0) ? '0 : GAP_W'(FRAME_GAP - 1);

  logic [1:0]             state;
  logic [NUM_CH*DW-1:0]   shadow;
  logic [SEL_W-1:0]       sel_q;
  logic                   last_q;
  logic [SEL_W-1:0]       sel_cnt;
  logic                   sel_last;
  logic [GAP_W-1:0]       unused_gap_cnt;
  logic                   gap_last;
  logic                   load_fire;
  logic                   advance;
  logic [DW-1:0]          ch_data;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign load_fire  = load_ready && load_valid;
  assign advance    = (state == ST_SHIFT) && !hold;

  // The index stops at 7 after the last channel; only a new load returns it to 0.
  tdm_sel_counter #(.W(SEL_W)) u_sel_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_fire),
    .en      (advance && !sel_last),
    .max_val (SEL_W'(NUM_CH - 1)),
    .cnt     (sel_cnt),
    .last    (sel_last)
  );

  // Cleared as SHIFT hands over to GAP, so GAP lasts exactly FRAME_GAP cycles.
  tdm_sel_counter #(.W(GAP_W)) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (advance && sel_last),
    .en      (state == ST_GAP),
    .max_val (GAP_MAX),
    .cnt     (unused_gap_cnt),
    .last    (gap_last)
  );

  always_comb begin
    ch_data = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (sel_cnt == ch_sel(k)) begin
        ch_data = shadow[(k-1)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      A          <= '0;
      sel_q      <= '0;
      a_valid    <= 1'b0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      a_valid    <= 1'b0;
      last_q     <= 1'b0;
      // Pulse one cycle after channel 8 is on the line.
      frame_done <= last_q;
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            shadow <= din;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // While held, A and S keep the last channel and a_valid drops.
          if (!hold) begin
            A       <= ch_data;
            sel_q   <= sel_cnt;
            a_valid <= 1'b1;
            if (sel_last) begin
              last_q <= 1'b1;
              state  <= (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign S3 = sel_q[2];
  assign S2 = sel_q[1];
  assign S1 = sel_q[0];

endmodule
